// File: rtl/io_seg7_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Mode encodings, the blank segment pattern and the hex segment table.
package io_seg7_pkg;

  typedef enum logic [1:0] {
    MODE_P0     = 2'b00,
    MODE_P1     = 2'b01,
    MODE_SPLIT  = 2'b10,
    MODE_P0_ALT = 2'b11
  } mode_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; the leftmost entry is nibble F.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/io_seg7_scan_if.sv
// Bundle between the CPU output registers and the display scanner.
// The master drives port values and display controls; the slave drives the display.
interface io_seg7_scan_if;

  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [1:0]  mode;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport master (
    output out_port0, out_port1, mode, blank_lz,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  out_port0, out_port1, mode, blank_lz,
    output an, seg, dp, frame_tick
  );

endinterface

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment decoder.
module hex7seg
  import io_seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/io_seg7_scan.sv
// Eight-digit multiplexed hex display driven from two CPU output ports.
// A shadow copy is taken at each frame boundary so a frame never tears.
module io_seg7_scan
  import io_seg7_pkg::*;
#(
  parameter int DIV  = 50000,
  parameter int NDIG = 8
) (
  input logic           clk,
  input logic           clrn,
  io_seg7_scan_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(NDIG);

  logic [CW-1:0] cnt;
  logic [DW-1:0] dig;
  logic [31:0]   shadow_val;
  mode_e         shadow_mode;
  logic          shadow_blank;

  logic          slot_end;
  logic          frame_end;
  logic [31:0]   sel_val;
  logic [3:0]    nib;
  logic [6:0]    hex_seg;
  logic          split;
  logic          lower_half;
  logic [DW-1:0] anchor;
  logic          lz_run;
  logic          blank;

  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          tick_q;

  assign slot_end  = (cnt == CW'(DIV - 1));
  assign frame_end = slot_end && (dig == DW'(NDIG - 1));

  always_comb begin
    // NOTE: default first so every path assigns sel_val and no latch is inferred.
    sel_val = bus.out_port0;
    case (bus.mode)
      MODE_P1:    sel_val = bus.out_port1;
      MODE_SPLIT: sel_val = {bus.out_port1[15:0], bus.out_port0[15:0]};
      default:    ;
    endcase
  end

  assign nib = shadow_val[{dig, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nib (nib),
    .seg (hex_seg)
  );

  // In split mode each half blanks on its own, anchored at its rightmost digit.
  assign split      = (shadow_mode == MODE_SPLIT);
  assign lower_half = split && (dig < DW'(NDIG / 2));
  assign anchor     = (split && !lower_half) ? DW'(NDIG / 2) : '0;

  always_comb begin
    lz_run = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= int'(dig) && !(lower_half && i >= NDIG / 2) &&
          shadow_val[4*i +: 4] != 4'h0)
        lz_run = 1'b0;
    end
  end

  assign blank = shadow_blank && lz_run && (dig != anchor);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt          <= '0;
      dig          <= '0;
      shadow_val   <= '0;
      shadow_mode  <= MODE_P0;
      shadow_blank <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge state of the others.
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end)
        dig <= dig + 1'b1;
      if (frame_end) begin
        shadow_val   <= sel_val;
        shadow_mode  <= mode_e'(bus.mode);
        shadow_blank <= bus.blank_lz;
      end
      tick_q <= frame_end;
      an_q   <= blank ? 8'hFF : ~(8'd1 << dig);
      seg_q  <= blank ? SEG_OFF : hex_seg;
      dp_q   <= !(split && dig == DW'(NDIG / 2));
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;

endmodule
